// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: drives the data-memory request/ready handshake,
// stalls the front of the pipeline while an access is outstanding, and registers MEM/WB.
module mem_stage_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RegWrite_in,
    input  logic        MemWrite_in,
    input  logic        MemRead_in,
    input  logic        mem_to_reg_in,
    input  logic        ret_future_in,
    input  logic        HALT_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result_in,
    input  logic [15:0] save_word_data_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        stall,
    output logic        RegWrite_out,
    output logic        mem_to_reg_out,
    output logic        ret_future_out,
    output logic        HALT_out,
    output logic [3:0]  reg_rd_out,
    output logic [15:0] alu_result_out,
    output logic [15:0] mem_data_out,
    output logic        mem_err
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state_reg;
    logic [7:0] cnt_reg;
    logic       memop;
    logic       last_wait;

    assign memop     = MemRead_in | MemWrite_in;
    assign last_wait = (cnt_reg == CNT_LAST);

    always_comb begin
        stall = 1'b0;
        if (rst_n) begin
            case (state_reg)
                IDLE: stall = memop;
                BUSY: stall = ~mem_rdy & ~last_wait;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 8'd0;
            mem_addr       <= 16'h0000;
            mem_wdata      <= 16'h0000;
            mem_re         <= 1'b0;
            mem_we         <= 1'b0;
            RegWrite_out   <= 1'b0;
            mem_to_reg_out <= 1'b0;
            ret_future_out <= 1'b0;
            HALT_out       <= 1'b0;
            reg_rd_out     <= 4'd0;
            alu_result_out <= 16'h0000;
            mem_data_out   <= 16'h0000;
            mem_err        <= 1'b0;
        end else begin
            // Bubble by default; capturing branches override the control fields.
            RegWrite_out   <= 1'b0;
            mem_to_reg_out <= 1'b0;
            ret_future_out <= 1'b0;
            HALT_out       <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (memop) begin
                        state_reg <= BUSY;
                        cnt_reg   <= 8'd0;
                        mem_addr  <= alu_result_in;
                        mem_wdata <= save_word_data_in;
                        mem_we    <= MemWrite_in;
                        mem_re    <= MemRead_in & ~MemWrite_in;
                    end else begin
                        RegWrite_out   <= RegWrite_in;
                        mem_to_reg_out <= mem_to_reg_in;
                        ret_future_out <= ret_future_in;
                        HALT_out       <= HALT_in;
                        reg_rd_out     <= reg_rd_in;
                        alu_result_out <= alu_result_in;
                        mem_data_out   <= 16'h0000;
                    end
                end
                BUSY: begin
                    if (mem_rdy || last_wait) begin
                        state_reg      <= IDLE;
                        mem_re         <= 1'b0;
                        mem_we         <= 1'b0;
                        mem_to_reg_out <= mem_to_reg_in;
                        ret_future_out <= ret_future_in;
                        HALT_out       <= HALT_in;
                        reg_rd_out     <= reg_rd_in;
                        alu_result_out <= alu_result_in;
                        if (mem_rdy) begin
                            RegWrite_out <= RegWrite_in;
                            mem_data_out <= mem_re ? mem_rdata : 16'h0000;
                        end else begin
                            // Timed-out access: suppress the write-back and flag it.
                            RegWrite_out <= 1'b0;
                            mem_data_out <= 16'h0000;
                            mem_err      <= 1'b1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl (TIMEOUT=4): reset, load, store wait-states,
// read+write collision, back-to-back loads with HALT, and watchdog timeout.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, ret_future_in, HALT_in;
    logic [3:0]  reg_rd_in;
    logic [15:0] alu_result_in, save_word_data_in;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_re, mem_we, mem_rdy, stall;
    logic        RegWrite_out, mem_to_reg_out, ret_future_out, HALT_out;
    logic [3:0]  reg_rd_out;
    logic [15:0] alu_result_out, mem_data_out;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_stage_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .RegWrite_in(RegWrite_in), .MemWrite_in(MemWrite_in), .MemRead_in(MemRead_in),
        .mem_to_reg_in(mem_to_reg_in), .ret_future_in(ret_future_in), .HALT_in(HALT_in),
        .reg_rd_in(reg_rd_in), .alu_result_in(alu_result_in), .save_word_data_in(save_word_data_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .stall(stall),
        .RegWrite_out(RegWrite_out), .mem_to_reg_out(mem_to_reg_out),
        .ret_future_out(ret_future_out), .HALT_out(HALT_out),
        .reg_rd_out(reg_rd_out), .alu_result_out(alu_result_out),
        .mem_data_out(mem_data_out), .mem_err(mem_err)
    );

    task automatic set_op(input logic rw, input logic mw, input logic mr, input logic m2r,
                          input logic ret, input logic halt, input logic [3:0] rd,
                          input logic [15:0] alu, input logic [15:0] wd);
        RegWrite_in = rw; MemWrite_in = mw; MemRead_in = mr; mem_to_reg_in = m2r;
        ret_future_in = ret; HALT_in = halt; reg_rd_in = rd;
        alu_result_in = alu; save_word_data_in = wd;
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({mem_re, mem_we, stall, RegWrite_out, HALT_out, mem_err} !== 6'b0 ||
            mem_addr !== 16'h0 || alu_result_out !== 16'h0 || reg_rd_out !== 4'h0) begin
            bad++; $display("FAIL reset_init: got re=%b we=%b stall=%b addr=%h alu=%h, want all 0",
                            mem_re, mem_we, stall, mem_addr, alu_result_out);
        end
        rst_n = 1'b1;
        set_op(1, 0, 1, 1, 0, 0, 4'd9, 16'h0ABC, 16'h0);
        mem_rdy = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_re !== 1'b1 || stall !== 1'b1) begin
            bad++; $display("FAIL reset_busy: got re=%b stall=%b, want 1 1", mem_re, stall);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (mem_re !== 1'b0 || stall !== 1'b0 || mem_addr !== 16'h0 || mem_err !== 1'b0 ||
            RegWrite_out !== 1'b0 || mem_data_out !== 16'h0) begin
            bad++; $display("FAIL reset_mid: got re=%b stall=%b addr=%h, want 0 0 0000",
                            mem_re, stall, mem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        set_op(1, 0, 0, 0, 0, 0, 4'd3, 16'h1234, 16'h0);
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++; $display("FAIL reset_alu_stall: got %b want 0", stall);
        end
        @(posedge clk); #1;
        total++;
        if (reg_rd_out !== 4'd3 || alu_result_out !== 16'h1234 || RegWrite_out !== 1'b1 || mem_re !== 1'b0) begin
            bad++; $display("FAIL reset_alu: got rd=%0d alu=%h rw=%b re=%b, want 3 1234 1 0",
                            reg_rd_out, alu_result_out, RegWrite_out, mem_re);
        end
        $display("reset: mid-BUSY reset and ALU op done");
    endtask

    task automatic test_load;
        @(negedge clk);
        set_op(1, 0, 1, 1, 0, 0, 4'd5, 16'h0040, 16'h0);
        mem_rdy = 1'b0;
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL lw_stall0: got %b want 1", stall); end
        @(posedge clk); #1;
        total++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0040 || RegWrite_out !== 1'b0 || mem_to_reg_out !== 1'b0) begin
            bad++; $display("FAIL lw_req: got re=%b we=%b addr=%h rw=%b, want 1 0 0040 0",
                            mem_re, mem_we, mem_addr, RegWrite_out);
        end
        @(negedge clk);
        mem_rdy = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall1: got %b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (mem_re !== 1'b0 || mem_data_out !== 16'hBEEF || mem_to_reg_out !== 1'b1 ||
            RegWrite_out !== 1'b1 || reg_rd_out !== 4'd5 || alu_result_out !== 16'h0040) begin
            bad++; $display("FAIL lw_done: got re=%b data=%h m2r=%b rw=%b rd=%0d, want 0 BEEF 1 1 5",
                            mem_re, mem_data_out, mem_to_reg_out, RegWrite_out, reg_rd_out);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        $display("load: LW 0040 -> %h", mem_data_out);
    endtask

    task automatic test_both;
        set_op(1, 1, 1, 1, 0, 0, 4'd2, 16'h0300, 16'h1111);
        #1;
        total++;
        if (stall !== 1'b1) begin bad++; $display("FAIL both_stall: got %b want 1", stall); end
        @(posedge clk); #1;
        total++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_wdata !== 16'h1111 || mem_data_out !== 16'hBEEF) begin
            bad++; $display("FAIL both_req: got we=%b re=%b wd=%h data=%h, want 1 0 1111 BEEF",
                            mem_we, mem_re, mem_wdata, mem_data_out);
        end
        @(negedge clk);
        mem_rdy = 1'b1; mem_rdata = 16'hDEAD;
        @(posedge clk); #1;
        total++;
        if (mem_data_out !== 16'h0000 || mem_we !== 1'b0 || alu_result_out !== 16'h0300) begin
            bad++; $display("FAIL both_done: got data=%h we=%b alu=%h, want 0000 0 0300",
                            mem_data_out, mem_we, alu_result_out);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        $display("both: read+write treated as write, data=%h", mem_data_out);
    endtask

    task automatic test_store;
        set_op(0, 1, 0, 0, 1, 0, 4'd0, 16'h0100, 16'hA5A5);
        mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (stall !== 1'b1) begin bad++; $display("FAIL sw_stall%0d: got %b want 1", i, stall); end
            @(posedge clk); #1;
            total++;
            if (mem_we !== 1'b1 || mem_addr !== 16'h0100 || mem_wdata !== 16'hA5A5 ||
                ret_future_out !== 1'b0 || alu_result_out !== 16'h0300) begin
                bad++; $display("FAIL sw_hold%0d: got we=%b addr=%h wd=%h ret=%b alu=%h, want 1 0100 A5A5 0 0300",
                                i, mem_we, mem_addr, mem_wdata, ret_future_out, alu_result_out);
            end
            @(negedge clk);
        end
        mem_rdy = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL sw_stall_end: got %b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (mem_we !== 1'b0 || ret_future_out !== 1'b1 || alu_result_out !== 16'h0100 || mem_err !== 1'b0) begin
            bad++; $display("FAIL sw_done: got we=%b ret=%b alu=%h err=%b, want 0 1 0100 0",
                            mem_we, ret_future_out, alu_result_out, mem_err);
        end
        @(negedge clk);
        mem_rdy = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        $display("store: SW A5A5 -> 0100 with 3 wait cycles");
    endtask

    task automatic test_back_to_back;
        int stall_cnt = 0;
        int halt_cnt  = 0;
        int halt_cyc  = -1;
        for (int c = 0; c < 6; c++) begin
            case (c)
                0: begin set_op(1, 0, 1, 1, 0, 0, 4'd1, 16'h0010, 16'h0); mem_rdy = 1'b0; end
                1: begin mem_rdy = 1'b1; mem_rdata = 16'h1111; end
                2: begin set_op(1, 0, 1, 1, 0, 0, 4'd2, 16'h0020, 16'h0); mem_rdy = 1'b0; end
                3: begin mem_rdy = 1'b1; mem_rdata = 16'h2222; end
                4: begin set_op(0, 0, 0, 0, 0, 1, 4'd0, 16'h0, 16'h0); mem_rdy = 1'b0; end
                default: set_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
            endcase
            #1;
            if (stall === 1'b1) stall_cnt++;
            @(posedge clk); #1;
            if (HALT_out === 1'b1) begin halt_cnt++; halt_cyc = c; end
            if (c == 3) begin
                total++;
                if (mem_data_out !== 16'h2222 || reg_rd_out !== 4'd2) begin
                    bad++; $display("FAIL b2b_lw2: got data=%h rd=%0d, want 2222 2", mem_data_out, reg_rd_out);
                end
            end
            @(negedge clk);
        end
        total++;
        if (stall_cnt != 2) begin bad++; $display("FAIL b2b_stalls: got %0d want 2", stall_cnt); end
        total++;
        if (halt_cnt != 1 || halt_cyc != 4) begin
            bad++; $display("FAIL b2b_halt: got count=%0d cycle=%0d, want 1 4", halt_cnt, halt_cyc);
        end
        $display("back_to_back: stalls=%0d halt_cycle=%0d", stall_cnt, halt_cyc);
    endtask

    task automatic test_timeout;
        set_op(1, 0, 1, 1, 0, 0, 4'd7, 16'h0200, 16'h0);
        mem_rdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++;
            if (stall !== 1'b1 || mem_err !== 1'b0) begin
                bad++; $display("FAIL to_stall%0d: got stall=%b err=%b, want 1 0", i, stall, mem_err);
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        total++;
        if (stall !== 1'b0) begin bad++; $display("FAIL to_abort_stall: got %b want 0", stall); end
        @(posedge clk); #1;
        total++;
        if (mem_err !== 1'b1 || RegWrite_out !== 1'b0 || mem_data_out !== 16'h0 ||
            mem_re !== 1'b0 || reg_rd_out !== 4'd7 || mem_to_reg_out !== 1'b1) begin
            bad++; $display("FAIL to_abort: got err=%b rw=%b data=%h re=%b rd=%0d, want 1 0 0000 0 7",
                            mem_err, RegWrite_out, mem_data_out, mem_re, reg_rd_out);
        end
        @(negedge clk);
        set_op(1, 0, 0, 0, 0, 0, 4'd4, 16'h0055, 16'h0);
        @(posedge clk); #1;
        total++;
        if (mem_err !== 1'b1 || RegWrite_out !== 1'b1 || alu_result_out !== 16'h0055) begin
            bad++; $display("FAIL to_sticky: got err=%b rw=%b alu=%h, want 1 1 0055",
                            mem_err, RegWrite_out, alu_result_out);
        end
        $display("timeout: LW 0200 aborted, mem_err=%b", mem_err);
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rdy = 1'b0;
        mem_rdata = 16'h0;
        set_op(0, 0, 0, 0, 0, 0, 4'd0, 16'h0, 16'h0);
        test_reset;
        test_load;
        test_both;
        test_store;
        test_back_to_back;
        test_timeout;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage_ctrl.md
# mem_stage_ctrl

Memory-stage controller of the 5-stage WISC-S15 pipeline, sitting between the EX/MEM pipeline register and the MEM/WB pipeline register. It consumes the EX/MEM control and data fields, runs a request/ready handshake with the data memory for loads and stores, stalls the front of the pipeline while an access is outstanding, and registers the MEM/WB fields. A watchdog bounds every access and flags a memory error on timeout.

## Interface
Parameters:
- TIMEOUT, 255: maximum BUSY cycles without mem_rdy before abort, range 1..255.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- RegWrite_in, MemWrite_in, MemRead_in, mem_to_reg_in, ret_future_in, HALT_in  in  1 each  EX/MEM control fields.
- reg_rd_in  in  4  destination register.
- alu_result_in  in  16  ALU result, also the memory address.
- save_word_data_in  in  16  store data.
- mem_addr  out  16  data memory address.
- mem_wdata  out  16  data memory write data.
- mem_re, mem_we  out  1 each  read/write request, level, held until ready.
- mem_rdata  in  16  read data, valid when mem_rdy=1.
- mem_rdy  in  1  access complete.
- stall  out  1  combinational; holds PC, IF/ID, ID/EX and EX/MEM.
- RegWrite_out, mem_to_reg_out, ret_future_out, HALT_out  out  1 each  MEM/WB control.
- reg_rd_out  out  4; alu_result_out, mem_data_out  out  16  MEM/WB data.
- mem_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, BUSY.
- memop = MemRead_in | MemWrite_in. Both asserted: treated as a write, and mem_data_out = 16'h0000.
- IDLE, memop=0: stall=0; MEM/WB captures all EX/MEM fields; mem_data_out <= 0.
- IDLE, memop=1: stall=1; next state BUSY; mem_addr <= alu_result_in, mem_wdata <= save_word_data_in; mem_we <= MemWrite_in, mem_re <= MemRead_in & ~MemWrite_in; counter <= 0; MEM/WB captures a bubble.
- BUSY, mem_rdy=0, counter < TIMEOUT-1: stall=1; counter++; bubble into MEM/WB; mem_re/we, mem_addr and mem_wdata are held stable.
- BUSY, mem_rdy=1: stall=0; MEM/WB captures the EX/MEM fields, and mem_data_out <= mem_rdata on a read; mem_re/we <= 0; next state IDLE.
- BUSY, mem_rdy=0, counter = TIMEOUT-1: the access is aborted. stall=0; MEM/WB captures the EX/MEM fields with RegWrite_out forced to 0 and mem_data_out <= 0; mem_err <= 1; mem_re/we <= 0; next state IDLE.
- Bubble: RegWrite_out, mem_to_reg_out, ret_future_out and HALT_out are 0. reg_rd_out, alu_result_out and mem_data_out hold their values.
- mem_rdy is ignored in IDLE.
- mem_err is cleared only by rst_n.
- Counter is 8 bits and never wraps; the abort fires first.
- Every output is registered except stall.

## Timing
- Non-memory instruction: MEM/WB is valid 1 cycle after EX/MEM, with no stall.
- Memory instruction, with mem_rdy seen in the first BUSY cycle: exactly 1 stall cycle, and MEM/WB is valid 2 cycles after EX/MEM.
- Each additional wait cycle adds 1 stall cycle.
- Timeout: stall lasts TIMEOUT cycles, and the abort completes on the next edge.
- Back-to-back memops: the IDLE cycle after a completion issues the next request, so there is no dead cycle beyond the IDLE decision cycle.
- Reset (asynchronous, any state including mid-BUSY):
  - state = IDLE, counter = 0.
  - mem_re = mem_we = 0; mem_addr = mem_wdata = 0.
  - All MEM/WB outputs = 0; mem_err = 0.
  - stall = 0 while rst_n = 0.
  - An aborted access is not retried.

## Test plan
- Reset mid-BUSY with mem_re=1 → same cycle: mem_re=0, stall=0, and all outputs 0. After release, an ALU op with rd=3, result 16'h1234 gives reg_rd_out=3, alu_result_out=16'h1234 and RegWrite_out=1 one cycle later.
- LW from address 16'h0040, mem_rdy in the first BUSY cycle, rdata 16'hBEEF → stall high for exactly 1 cycle, mem_re high for 1 cycle, then mem_data_out=16'hBEEF with mem_to_reg_out=1.
- SW of 16'hA5A5 to 16'h0100 with mem_rdy after 3 wait cycles → stall high for 4 cycles, mem_we/mem_addr/mem_wdata stable throughout, and bubbles in MEM/WB for 4 cycles.
- TIMEOUT=4, LW with mem_rdy never asserted → stall for 4 cycles, then mem_err=1, RegWrite_out=0, mem_data_out=0; mem_err stays 1 for the following instructions.
- MemRead_in=MemWrite_in=1 → only mem_we asserted, and mem_data_out=0 on completion.
- Two back-to-back LWs, each with immediate mem_rdy, followed by a HALT → 2 stall cycles in total; HALT_out=1 appears only in the cycle HALT reaches MEM/WB, and is never 1 during a bubble.
